// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: redirect in, imem request/response, decode handoff.
// Latency: none (wires only).
// Backpressure: imem_req_ready_i and instr_ready_i; responses are never stalled.
interface fetch_unit_if;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;

    // Fetch unit side
    modport master (
        input  redirect_valid_i, redirect_pc_i,
        output imem_req_valid_o, imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_rsp_valid_i, imem_rsp_data_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i
    );

    // Environment side (memory, decode, redirect source)
    modport slave (
        output redirect_valid_i, redirect_pc_i,
        input  imem_req_valid_o, imem_req_addr_o,
        output imem_req_ready_i,
        output imem_rsp_valid_i, imem_rsp_data_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, pairs responses with PCs.
// Latency: 2 cycles minimum from request handshake to instr_valid_o (1-cycle memory).
// Backpressure: at most DEPTH allocated+in-flight requests; redirect flushes and drops late responses.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    fetch_unit_if.master bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef enum logic [0:0] {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    // Control state
    state_t      state_q, state_d;
    cnt_t        discard_q, discard_d;
    logic [63:0] pc_q, pc_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    ptr_t        rptr_q, rptr_d;   // oldest unfilled slot
    cnt_t        count_q, count_d;
    cnt_t        pend_q, pend_d;   // allocated but not yet filled

    // Buffer storage
    logic [63:0] ent_pc_q  [DEPTH];
    logic [31:0] ent_dat_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    // Handshake qualifiers
    logic req_vld, instr_vld;
    logic req_hs, deq_hs, rsp_fill;
    logic unused_pc_lsbs;

    assign unused_pc_lsbs = ^bus.redirect_pc_i[1:0];

    assign req_hs   = req_vld && bus.imem_req_ready_i;
    assign deq_hs   = instr_vld && bus.instr_ready_i;
    // A response is only kept in RUN and outside a redirect cycle
    assign rsp_fill = bus.imem_rsp_valid_i && (state_q == S_RUN) && !bus.redirect_valid_i;

    // FSM state register and discard counter
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_RUN;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // FSM next state: redirect accumulates stale responses to drop, FLUSH drains them
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        if (bus.redirect_valid_i) begin
            discard_d = discard_q + pend_q - cnt_t'(bus.imem_rsp_valid_i);
            state_d   = (discard_d != '0) ? S_FLUSH : S_RUN;
        end else if ((state_q == S_FLUSH) && bus.imem_rsp_valid_i) begin
            discard_d = discard_q - CNT_ONE;
            if (discard_q == CNT_ONE) begin
                state_d = S_RUN;
            end
        end
    end

    // FSM outputs: valids gated combinationally only by redirect and reset
    always_comb begin
        req_vld   = (state_q == S_RUN) && (count_q < DEPTH_C) &&
                    !bus.redirect_valid_i && !rst_in;
        instr_vld = filled_q[head_q] && !bus.redirect_valid_i;
    end

    // Pointer, counter and PC next-state
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        pend_d  = pend_q;
        if (bus.redirect_valid_i) begin
            pc_d    = {bus.redirect_pc_i[63:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end else begin
            if (req_hs) begin
                pc_d   = pc_q + 64'd4;
                tail_d = tail_q + PTR_ONE;
            end
            if (deq_hs) begin
                head_d = head_q + PTR_ONE;
            end
            if (rsp_fill) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            count_d = count_q + cnt_t'(req_hs) - cnt_t'(deq_hs);
            pend_d  = pend_q + cnt_t'(req_hs) - cnt_t'(rsp_fill);
        end
    end

    // Pointer, counter and PC registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    // Buffer entries: allocate at request, fill at response, free at dequeue
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]  <= '0;
                ent_dat_q[i] <= '0;
            end
            filled_q <= '0;
        end else if (bus.redirect_valid_i) begin
            filled_q <= '0;
        end else begin
            // tail, rptr and head never collide on an active operation:
            // tail==head only when empty/full, rptr==tail only with nothing pending
            if (req_hs) begin
                ent_pc_q[tail_q] <= pc_q;
                filled_q[tail_q] <= 1'b0;
            end
            if (rsp_fill) begin
                ent_dat_q[rptr_q] <= bus.imem_rsp_data_i;
                filled_q[rptr_q]  <= 1'b1;
            end
            if (deq_hs) begin
                filled_q[head_q] <= 1'b0;
            end
        end
    end

    assign bus.imem_req_valid_o = req_vld;
    assign bus.imem_req_addr_o  = pc_q;
    assign bus.instr_valid_o    = instr_vld;
    assign bus.instr_o          = ent_dat_q[head_q];
    assign bus.instr_pc_o       = ent_pc_q[head_q];

endmodule
